// File: rtl/sync_fork.sv
// Clocked four-phase request fork: one upstream rin/ain channel drives two downstream
// r/a channels, with synchronised inputs, latched branch mask, stall watchdog and handshake counter.

module sync_fork_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (reset) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[STAGES-2:0], d};
  end

  assign q = sync_pipe[STAGES-1];
endmodule

module sync_fork #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rin,
  output logic             ain,
  output logic             r1,
  input  logic             a1,
  output logic             r2,
  input  logic             a2,
  input  logic             en1,
  input  logic             en2,
  output logic             timeout,
  output logic [CNT_W-1:0] hs_count
);
  typedef enum logic [1:0] {IDLE, REQ, ACKED, RELEASE} state_t;

  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

  state_t               state, state_nxt;
  logic                 rin_s, a1_s, a2_s;
  logic [1:0]           mask, mask_nxt;
  logic                 ain_nxt, r1_nxt, r2_nxt;
  logic                 done, ackd, clr, busy;
  logic [TIMEOUT_W-1:0] wd;
  logic                 wd_fired;

  // One synchroniser lane per async input: {a2, a1, rin}
  sync_fork_sync #(.STAGES(SYNC_STAGES)) u_sync [2:0] (
    .clk   (clk),
    .reset (reset),
    .d     ({a2, a1, rin}),
    .q     ({a2_s, a1_s, rin_s})
  );

  // Disabled branches count as both acknowledged and cleared
  assign ackd = (a1_s | ~mask[0]) & (a2_s | ~mask[1]);
  assign clr  = (~a1_s | ~mask[0]) & (~a2_s | ~mask[1]);
  assign busy = (state == REQ) || (state == RELEASE);

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    ain_nxt   = ain;
    r1_nxt    = r1;
    r2_nxt    = r2;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (rin_s) begin
          mask_nxt = {en2, en1};
          if (en1 | en2) begin
            r1_nxt    = en1;
            r2_nxt    = en2;
            state_nxt = REQ;
          end else begin
            ain_nxt   = 1'b1;
            state_nxt = ACKED;
          end
        end
      end
      REQ: begin
        if (ackd) begin
          ain_nxt   = 1'b1;
          state_nxt = ACKED;
        end
      end
      ACKED: begin
        if (!rin_s) begin
          r1_nxt = 1'b0;
          r2_nxt = 1'b0;
          if (mask != 2'b00) begin
            state_nxt = RELEASE;
          end else begin
            ain_nxt   = 1'b0;
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      RELEASE: begin
        if (clr) begin
          ain_nxt   = 1'b0;
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mask     <= 2'b00;
      ain      <= 1'b0;
      r1       <= 1'b0;
      r2       <= 1'b0;
      hs_count <= '0;
    end else begin
      state <= state_nxt;
      mask  <= mask_nxt;
      ain   <= ain_nxt;
      r1    <= r1_nxt;
      r2    <= r2_nxt;
      if (done) hs_count <= hs_count + 1'b1;
    end
  end

  // Watchdog saturates at WD_MAX; the fired flag limits it to one pulse per state visit
  always_ff @(posedge clk) begin
    if (reset) begin
      wd       <= '0;
      wd_fired <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= busy && (wd == WD_MAX) && !wd_fired;
      if (state_nxt != state) begin
        wd       <= '0;
        wd_fired <= 1'b0;
      end else if (busy) begin
        if (wd != WD_MAX) wd <= wd + 1'b1;
        else              wd_fired <= 1'b1;
      end
    end
  end
endmodule
